gradient_compute: RTL and testbench

GRADIENT_COMPUTE -- requirements
Module: gradient_compute

---
 rtl/gradient_compute.sv | 173 +++++++++++++++++
 tb/tb_gradient_compute.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/gradient_compute.sv
// Streaming central-difference gradient (gx, gy) over a raster image using two line buffers.
// Optional GRADIENT_MAG_EN adds a registered saturated |gx|+|gy| output (grad_mag).
module gradient_compute #(
  parameter int DATA_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] pixel,
  output logic                  in_ready,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH:0]   gx,
  output logic [DATA_WIDTH:0]   gy,
  output logic                  out_last
`ifdef GRADIENT_MAG_EN
  ,
  output logic [DATA_WIDTH:0]   grad_mag
`endif
);

  localparam int GW = DATA_WIDTH + 1;
  localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  logic [DATA_WIDTH-1:0] lb1_mem [IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0] lb2_mem [IMAGE_WIDTH];

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] win1_q [2];
  logic [DATA_WIDTH-1:0] win1_d [2];
  logic [DATA_WIDTH-1:0] win2_q, win2_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic                  out_valid_q, out_valid_d;
  logic [GW-1:0]         gx_q, gx_d, gy_q, gy_d;
  logic                  out_last_q, out_last_d;

  logic [DATA_WIDTH-1:0] lb1_rd_s, lb2_rd_s;
  logic                  accept_s, produce_s, frame_end_s;
  logic [GW-1:0]         gx_calc_s, gy_calc_s;

`ifdef GRADIENT_MAG_EN
  logic [GW-1:0]         mag_q, mag_d;

  function automatic logic [GW-1:0] abs_val(input logic [GW-1:0] v);
    if (v[GW-1]) begin
      return (~v) + GW'(1);
    end else begin
      return v;
    end
  endfunction

  function automatic logic [GW-1:0] mag_sat(input logic [GW-1:0] a, input logic [GW-1:0] b);
    logic [GW:0] sum;
    sum = {1'b0, abs_val(a)} + {1'b0, abs_val(b)};
    if (sum[GW]) begin
      return {GW{1'b1}};
    end else begin
      return sum[GW-1:0];
    end
  endfunction
`endif

  // Window columns: line-buffer read (col c), win1_q[0] (c-1), win1_q[1] (c-2).
  assign lb1_rd_s    = lb1_mem[col_q];
  assign lb2_rd_s    = lb2_mem[col_q];
  assign in_ready    = !out_valid_q || out_ready;
  assign accept_s    = in_valid && in_ready;
  assign produce_s   = accept_s && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign frame_end_s = (row_q == RW'(IMAGE_HEIGHT - 1)) && (col_q == CW'(IMAGE_WIDTH - 1));
  assign gx_calc_s   = {1'b0, lb1_rd_s} - {1'b0, win1_q[1]};
  assign gy_calc_s   = {1'b0, prev_q}   - {1'b0, win2_q};

  // Next-state for counters, windows and the output register.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win1_d      = win1_q;
    win2_d      = win2_q;
    prev_d      = prev_q;
    out_valid_d = out_valid_q;
    gx_d        = gx_q;
    gy_d        = gy_q;
    out_last_d  = out_last_q;
`ifdef GRADIENT_MAG_EN
    mag_d       = mag_q;
`endif
    if (accept_s) begin
      win1_d[0] = lb1_rd_s;
      win1_d[1] = win1_q[0];
      win2_d    = lb2_rd_s;
      prev_d    = pixel;
      if (col_q == CW'(IMAGE_WIDTH - 1)) begin
        col_d = '0;
        if (row_q == RW'(IMAGE_HEIGHT - 1)) begin
          row_d = '0;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      col_d = col_q;
    end
    // A new result overrides a simultaneous consume so there is no bubble.
    if (produce_s) begin
      out_valid_d = 1'b1;
      gx_d        = gx_calc_s;
      gy_d        = gy_calc_s;
      out_last_d  = frame_end_s;
`ifdef GRADIENT_MAG_EN
      mag_d       = mag_sat(gx_calc_s, gy_calc_s);
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win1_q[0]   <= '0;
      win1_q[1]   <= '0;
      win2_q      <= '0;
      prev_q      <= '0;
      out_valid_q <= 1'b0;
      gx_q        <= '0;
      gy_q        <= '0;
      out_last_q  <= 1'b0;
`ifdef GRADIENT_MAG_EN
      mag_q       <= '0;
`endif
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win1_q      <= win1_d;
      win2_q      <= win2_d;
      prev_q      <= prev_d;
      out_valid_q <= out_valid_d;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      out_last_q  <= out_last_d;
`ifdef GRADIENT_MAG_EN
      mag_q       <= mag_d;
`endif
    end
  end

  // Line buffers: row-1 takes the new pixel, row-2 takes the displaced row-1 entry.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb1_mem[col_q] <= pixel;
      lb2_mem[col_q] <= lb1_rd_s;
    end
  end

  assign out_valid = out_valid_q;
  assign gx        = gx_q;
  assign gy        = gy_q;
  assign out_last  = out_last_q;
`ifdef GRADIENT_MAG_EN
  assign grad_mag  = mag_q;
`endif

endmodule

// File: tb/tb_gradient_compute.sv
// Directed-vector bench for gradient_compute on an 8x6 image; expected results come from a frame-array model.
module tb_gradient_compute;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 8;
  localparam int NOUT = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] pixel;
  logic          in_ready;
  logic          out_ready;
  logic          out_valid;
  logic [DW:0]   gx, gy;
  logic          out_last;
`ifdef GRADIENT_MAG_EN
  logic [DW:0]   grad_mag;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int frame [H][W];
  int exp_gx [NOUT];
  int exp_gy [NOUT];
  int exp_last [NOUT];
  int exp_mag [NOUT];

  gradient_compute #(.DATA_WIDTH(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .pixel    (pixel),
    .in_ready (in_ready),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .gx       (gx),
    .gy       (gy),
    .out_last (out_last)
`ifdef GRADIENT_MAG_EN
    ,
    .grad_mag (grad_mag)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // mode: 0 const100, 1 10*col, 2 255-10*col, 3 40*row, 4 random, 5 const50
  task automatic fill(input int mode);
    int k;
    k = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (mode)
          0: frame[r][c] = 100;
          1: frame[r][c] = 10 * c;
          2: frame[r][c] = 255 - 10 * c;
          3: frame[r][c] = 40 * r;
          4: frame[r][c] = int'($urandom_range(0, 255));
          default: frame[r][c] = 50;
        endcase
      end
    end
    for (int r = 2; r < H; r++) begin
      for (int c = 2; c < W; c++) begin
        int a, b;
        exp_gx[k]   = frame[r-1][c] - frame[r-1][c-2];
        exp_gy[k]   = frame[r][c-1] - frame[r-2][c-1];
        exp_last[k] = (r == H - 1 && c == W - 1) ? 1 : 0;
        a = (exp_gx[k] < 0) ? -exp_gx[k] : exp_gx[k];
        b = (exp_gy[k] < 0) ? -exp_gy[k] : exp_gy[k];
        exp_mag[k]  = (a + b > 511) ? 511 : a + b;
        k++;
      end
    end
  endtask

  task automatic run_frame(input bit rnd);
    int idx, got, cyc;
    idx = 0;
    got = 0;
    cyc = 0;
    while ((idx < W * H || got < NOUT) && cyc < 3000) begin
      @(negedge clk);
      in_valid  = (idx < W * H) && (!rnd || ($urandom_range(0, 3) != 0));
      pixel     = (idx < W * H) ? DW'(frame[idx / W][idx % W]) : '0;
      out_ready = !rnd || ($urandom_range(0, 1) == 1);
      #1;
      check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (got < NOUT) begin
          check("gx",  32'(gx),  32'(exp_gx[got]) & 32'h1FF);
          check("gy",  32'(gy),  32'(exp_gy[got]) & 32'h1FF);
          check("out_last", 32'(out_last), 32'(exp_last[got]));
`ifdef GRADIENT_MAG_EN
          check("grad_mag", 32'(grad_mag), 32'(exp_mag[got]));
`endif
        end else begin
          check("extra_output", 32'(got + 1), 32'(NOUT));
        end
        got++;
      end
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    check("frame_pixels", 32'(idx), 32'(W * H));
    check("frame_outputs", 32'(got), 32'(NOUT));
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    pixel     = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_gx",        32'(gx),        32'd0);
    check("rst_gy",        32'(gy),        32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    @(negedge clk);
    rst = 1'b1;

    fill(0); run_frame(1'b0);
    fill(1); run_frame(1'b0);
    check("hramp_gx", 32'(exp_gx[5]), 32'd20);
    fill(2); run_frame(1'b0);
    check("inv_ramp_gx", 32'(exp_gx[0]) & 32'h1FF, 32'h1EC);
    fill(3); run_frame(1'b0);
    check("vramp_gy", 32'(exp_gy[7]), 32'd80);
    fill(4); run_frame(1'b1);

    // Partial frame of 20 pixels, then reset mid-frame with an output pending.
    fill(4);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      pixel     = DW'(frame[i / W][i % W]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_gx",        32'(gx),        32'd0);
    check("midrst_out_last",  32'(out_last),  32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("midrst_hold_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    fill(5); run_frame(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
